// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the simple CPU control path: micro-step state
// indices, the instruction opcode encoding, the opcode-to-execute-state map
// and the system bus source selects used by the control decoder.
package cpu_pkg;

    localparam int STATE_W = 4;

    // Micro-step indices; the one-hot state vector bit i corresponds to index i.
    localparam int FETCH1 = 0;
    localparam int FETCH2 = 1;
    localparam int FETCH3 = 2;
    localparam int ADD1   = 3;
    localparam int ADD2   = 4;
    localparam int AND1   = 5;
    localparam int AND2   = 6;
    localparam int JMP1   = 7;
    localparam int INC1   = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_JMP = 2'b10,
        OP_INC = 2'b11
    } opcode_e;

    // System bus driver selects shared with the control decoder.
    localparam logic [1:0] SYSBUS_PC  = 2'd0;
    localparam logic [1:0] SYSBUS_DR  = 2'd1;
    localparam logic [1:0] SYSBUS_MEM = 2'd2;

    // First execute state for each opcode.
    function automatic logic [STATE_W-1:0] op_to_state(input opcode_e op);
        case (op)
            OP_ADD:  return STATE_W'(ADD1);
            OP_AND:  return STATE_W'(AND1);
            OP_JMP:  return STATE_W'(JMP1);
            default: return STATE_W'(INC1);
        endcase
    endfunction

endpackage

// File: rtl/cpu_state_sequencer_onehot_dec.sv
// onehot_dec
// Parameterised combinational binary-to-one-hot decoder. Indices that have
// no corresponding output bit decode to all-zero.
//   idx    : binary index, IN_W bits
//   onehot : one-hot vector, OUT_W bits
module onehot_dec #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 9
) (
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (idx == IN_W'(i));
        end
    end

endmodule

// File: rtl/cpu_state_sequencer.sv
// cpu_state_sequencer
// Registered micro-step counter for the CPU control path. Advances under
// clear/load/increment commands (priority CLR > LD > INC), maps the opcode
// to the first execute state on a load, and drives a registered one-hot
// state vector. RUN/STEP gate advancement for single-stepping.
//   clk, rst          : clock, asynchronous active-high reset
//   COUNTER_CLR/LD/INC: commands from the control decoder
//   IR_OPCODE         : opcode field, sampled on a load
//   RUN, STEP         : free-run enable, single-step request (level)
//   CPU_state         : one-hot current state (registered)
//   STATE_IDX         : binary current state (registered)
//   STEP_ACK          : pulse, a requested single step was taken
//   INSTR_DONE        : pulse, a clear was applied
//   FAULT             : sticky, increment attempted past INC1 or from an illegal index
module cpu_state_sequencer
    import cpu_pkg::*;
#(
    parameter int states = 9,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              COUNTER_LD,
    input  logic              COUNTER_INC,
    input  logic              COUNTER_CLR,
    input  logic [1:0]        IR_OPCODE,
    input  logic              RUN,
    input  logic              STEP,
    output logic [states-1:0] CPU_state,
    output logic [CNT_W-1:0]  STATE_IDX,
    output logic              STEP_ACK,
    output logic              INSTR_DONE,
    output logic              FAULT
);

    logic              step_seen;
    logic              adv;
    logic              step_taken;
    logic              done_nxt;
    logic              fault_set;
    logic [CNT_W-1:0]  idx_nxt;
    logic [states-1:0] onehot_nxt;

    always_comb begin
        adv        = RUN | (STEP & ~step_seen);
        step_taken = ~RUN & STEP & ~step_seen;
        idx_nxt    = STATE_IDX;
        done_nxt   = 1'b0;
        fault_set  = 1'b0;

        // An index past INC1 is never held, even while frozen.
        if (STATE_IDX > CNT_W'(INC1)) begin
            idx_nxt = '0;
        end

        if (adv) begin
            if (COUNTER_CLR) begin
                idx_nxt  = '0;
                done_nxt = 1'b1;
            end else if (COUNTER_LD) begin
                idx_nxt = CNT_W'(op_to_state(opcode_e'(IR_OPCODE)));
            end else if (COUNTER_INC) begin
                if (STATE_IDX >= CNT_W'(INC1)) begin
                    idx_nxt   = '0;
                    fault_set = 1'b1;
                end else begin
                    idx_nxt = STATE_IDX + CNT_W'(1);
                end
            end
        end
    end

    // Decode the next index so the one-hot vector registers in step with STATE_IDX.
    onehot_dec #(
        .IN_W  (CNT_W),
        .OUT_W (states)
    ) u_onehot_dec (
        .idx    (idx_nxt),
        .onehot (onehot_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            STATE_IDX  <= '0;
            CPU_state  <= {{(states-1){1'b0}}, 1'b1};
            STEP_ACK   <= 1'b0;
            INSTR_DONE <= 1'b0;
            FAULT      <= 1'b0;
            step_seen  <= 1'b0;
        end else begin
            STATE_IDX  <= idx_nxt;
            CPU_state  <= onehot_nxt;
            STEP_ACK   <= step_taken;
            INSTR_DONE <= done_nxt;
            FAULT      <= FAULT | fault_set;
            // Held STEP yields a single advance; released STEP re-arms.
            step_seen  <= STEP ? (step_seen | step_taken) : 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_state_sequencer.sv
module tb_cpu_state_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       COUNTER_LD = 1'b0;
    logic       COUNTER_INC = 1'b0;
    logic       COUNTER_CLR = 1'b0;
    logic [1:0] IR_OPCODE = 2'b00;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic [8:0] CPU_state;
    logic [3:0] STATE_IDX;
    logic       STEP_ACK;
    logic       INSTR_DONE;
    logic       FAULT;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic [8:0] oh;
        logic       done;
        logic       ack;
        logic       fault;
    } obs_t;

    obs_t sb[$];

    // Reference model state
    int   m_idx   = 0;
    logic m_fault = 1'b0;
    logic m_seen  = 1'b0;

    cpu_state_sequencer #(.states(9), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .COUNTER_LD  (COUNTER_LD),
        .COUNTER_INC (COUNTER_INC),
        .COUNTER_CLR (COUNTER_CLR),
        .IR_OPCODE   (IR_OPCODE),
        .RUN         (RUN),
        .STEP        (STEP),
        .CPU_state   (CPU_state),
        .STATE_IDX   (STATE_IDX),
        .STEP_ACK    (STEP_ACK),
        .INSTR_DONE  (INSTR_DONE),
        .FAULT       (FAULT)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.idx   = STATE_IDX;
        o.oh    = CPU_state;
        o.done  = INSTR_DONE;
        o.ack   = STEP_ACK;
        o.fault = FAULT;
        return o;
    endfunction

    // Drive one cycle of stimulus, push the expected outcome, clock it.
    task automatic tick(input logic clr, input logic ld, input logic inc,
                        input logic [1:0] op, input logic run, input logic step);
        obs_t e;
        logic a;
        logic taken;
        COUNTER_CLR = clr;
        COUNTER_LD  = ld;
        COUNTER_INC = inc;
        IR_OPCODE   = op;
        RUN         = run;
        STEP        = step;
        a     = run | (step & ~m_seen);
        taken = ~run & step & ~m_seen;
        e.done = 1'b0;
        e.ack  = taken;
        if (a) begin
            if (clr) begin
                m_idx  = 0;
                e.done = 1'b1;
            end else if (ld) begin
                case (op)
                    2'b00:   m_idx = 3;
                    2'b01:   m_idx = 5;
                    2'b10:   m_idx = 7;
                    default: m_idx = 8;
                endcase
            end else if (inc) begin
                if (m_idx == 8) begin
                    m_idx   = 0;
                    m_fault = 1'b1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end
        m_seen  = step ? (m_seen | taken) : 1'b0;
        e.idx   = m_idx[3:0];
        e.oh    = 9'b1 << m_idx;
        e.fault = m_fault;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_idx   = 0;
        m_fault = 1'b0;
        m_seen  = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        #1 rst = 1'b1;
        #2;
        total++;
        if (CPU_state !== 9'h001 || STATE_IDX !== 4'd0 || STEP_ACK !== 1'b0 ||
            INSTR_DONE !== 1'b0 || FAULT !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: got oh=%h idx=%0d ack=%b done=%b fault=%b want oh=001 idx=0 ack=0 done=0 fault=0",
                     CPU_state, STATE_IDX, STEP_ACK, INSTR_DONE, FAULT);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Go to index 5, then reset asynchronously mid-cycle.
        tick(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd5) begin
            bad++;
            $display("FAIL reset_prep: got %h want %h", o, e);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (CPU_state !== 9'h001 || STATE_IDX !== 4'd0 || FAULT !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got oh=%h idx=%0d fault=%b want oh=001 idx=0 fault=0",
                     CPU_state, STATE_IDX, FAULT);
        end
        do_reset();
    endtask

    task automatic test_add_cycle();
        logic [2:0] cmd [5] = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b100};
        int         want_idx [5] = '{1, 2, 3, 4, 0};
        logic       want_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        obs_t e;
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            tick(cmd[i][2], cmd[i][1], cmd[i][0], 2'b00, 1'b1, 1'b0);
            e = sb.pop_front();
            o = sample();
            total++;
            if (o !== e || o.idx !== want_idx[i][3:0] || o.done !== want_done[i]) begin
                bad++;
                $display("FAIL add_cycle[%0d]: got %h want %h (idx %0d done %b)",
                         i, o, e, want_idx[i], want_done[i]);
            end
        end
    endtask

    task automatic test_load_map();
        int         want_idx [4] = '{3, 5, 7, 8};
        logic [8:0] want_oh  [4] = '{9'h008, 9'h020, 9'h080, 9'h100};
        obs_t e;
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            void'(sb.pop_front());
            tick(1'b0, 1'b1, 1'b0, 2'(i), 1'b1, 1'b0);
            e = sb.pop_front();
            o = sample();
            total++;
            if (o !== e || o.idx !== want_idx[i][3:0] || o.oh !== want_oh[i]) begin
                bad++;
                $display("FAIL load_map[op%0d]: got idx=%0d oh=%h want idx=%0d oh=%h",
                         i, o.idx, o.oh, want_idx[i], want_oh[i]);
            end
        end
    endtask

    task automatic test_priority();
        obs_t e;
        obs_t o;
        tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        sb.delete();
        total++;
        if (STATE_IDX !== 4'd2) begin
            bad++;
            $display("FAIL prio_setup: got idx=%0d want idx=2", STATE_IDX);
        end
        tick(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd0 || o.done !== 1'b1) begin
            bad++;
            $display("FAIL prio_clr: got %h want %h", o, e);
        end
        tick(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd7) begin
            bad++;
            $display("FAIL prio_ld: got %h want %h", o, e);
        end
    endtask

    task automatic test_fault();
        obs_t e;
        obs_t o;
        logic [2:0] cmd [4] = '{3'b010, 3'b001, 3'b100, 3'b100};
        logic       want_f [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick(cmd[i][2], cmd[i][1], cmd[i][0], 2'b11, 1'b1, 1'b0);
            e = sb.pop_front();
            o = sample();
            total++;
            if (o !== e || o.fault !== want_f[i]) begin
                bad++;
                $display("FAIL fault[%0d]: got %h (fault %b) want %h (fault %b)",
                         i, o, o.fault, e, want_f[i]);
            end
        end
        do_reset();
        total++;
        if (FAULT !== 1'b0 || STATE_IDX !== 4'd0) begin
            bad++;
            $display("FAIL fault_rst: got fault=%b idx=%0d want fault=0 idx=0", FAULT, STATE_IDX);
        end
    endtask

    task automatic test_single_step();
        obs_t e;
        obs_t o;
        int   acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
            e = sb.pop_front();
            o = sample();
            acks += int'(o.ack);
            total++;
            if (o !== e || o.idx !== 4'd1) begin
                bad++;
                $display("FAIL step_hold[%0d]: got %h want %h", i, o, e);
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL step_ack_count: got %0d want 1", acks);
        end
        tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd1 || o.ack !== 1'b0) begin
            bad++;
            $display("FAIL step_release: got %h want %h", o, e);
        end
        tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd2 || o.ack !== 1'b1) begin
            bad++;
            $display("FAIL step_again: got %h want %h", o, e);
        end
        // RUN takes over while STEP is still held: advance, no ack.
        tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd3 || o.ack !== 1'b0) begin
            bad++;
            $display("FAIL step_run: got %h want %h", o, e);
        end
        // Frozen with no step: commands ignored.
        tick(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        e = sb.pop_front();
        o = sample();
        total++;
        if (o !== e || o.idx !== 4'd3 || o.done !== 1'b0) begin
            bad++;
            $display("FAIL step_frozen: got %h want %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_add_cycle();
        test_load_map();
        test_priority();
        test_fault();
        test_single_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_state_sequencer.md
# cpu_state_sequencer

Registered state counter for the simple CPU control path. It holds the current micro-step index and advances it under the clear/load/increment commands from the control decoder. On a load it maps the instruction-register opcode to the first execute state, and it emits the one-hot `CPU_state` vector that the control decoder consumes combinationally. It also provides run/single-step gating and an instruction-complete pulse for the debug front end.

## Interface
- `states`, 9: width of the one-hot state vector; must be 9 for the current instruction set.
- `CNT_W`, 4: width of the binary step counter; must satisfy 2**CNT_W >= states.
- `clk` input 1: single system clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `COUNTER_LD` input 1: load the execute-entry state mapped from `IR_OPCODE`.
- `COUNTER_INC` input 1: advance to the next state.
- `COUNTER_CLR` input 1: return to FETCH1; marks end of instruction.
- `IR_OPCODE` input 2: opcode field of IR, sampled on a load.
- `RUN` input 1: 1 = free-running; 0 = frozen except for single steps.
- `STEP` input 1: single-step request, level; acted on only when `RUN`=0.
- `CPU_state` output `states`: one-hot current state, registered.
- `STATE_IDX` output `CNT_W`: binary current state, registered.
- `STEP_ACK` output 1: one-cycle pulse, a requested step was taken.
- `INSTR_DONE` output 1: one-cycle pulse, a clear was applied.
- `FAULT` output 1: sticky flag, illegal increment attempted; cleared only by `rst`.

## Operation
- State indices: FETCH1 0, FETCH2 1, FETCH3 2, ADD1 3, ADD2 4, AND1 5, AND2 6, JMP1 7, INC1 8. `CPU_state[i]`=1 iff `STATE_IDX`=i.
- Opcode map on load: 00 ADD -> 3; 01 AND -> 5; 10 JMP -> 7; 11 INC -> 8.
- Advance enable `adv` = `RUN` | (`STEP` & ~`step_seen`). `step_seen` is set when a step is taken and cleared when `STEP`=0, so a held `STEP` produces exactly one advance.
- When `adv`=0 the counter holds and the command inputs are ignored.
- When `adv`=1, commands resolve by priority CLR > LD > INC; with none asserted the counter holds.
  - CLR: index becomes 0 and `INSTR_DONE` pulses.
  - LD: index becomes map(`IR_OPCODE`).
  - INC: index becomes index+1, except from 8 (INC1) or from an out-of-range index (9..15). In those cases index becomes 0 and `FAULT` is set.
- `STEP_ACK` pulses on every edge where `RUN`=0 and a step was taken, whether or not a command was present.

## Timing
- All outputs are registered and update on the rising edge after the command is sampled. Command-to-state latency is 1 cycle.
- The decoder's commands for state N are sampled at the end of state N, so each state lasts exactly one cycle while `RUN`=1.
- Reset: `STATE_IDX`=0, `CPU_state`=9'b000000001, `STEP_ACK`=0, `INSTR_DONE`=0, `FAULT`=0, `step_seen`=0. Assertion mid-instruction takes effect immediately, without waiting for `clk`. The first command is taken on the first edge after release.
- `RUN` switching 0->1 while `STEP` is held: free-running takes over and no `STEP_ACK` is generated.
- `CPU_state` is never all-zero or multi-hot after reset. An illegal index cannot persist beyond one cycle.

## Structure
- Shared `cpu_pkg` holds:
  - state index localparams (FETCH1..INC1);
  - the opcode enum (OP_ADD, OP_AND, OP_JMP, OP_INC);
  - the `op_to_state` mapping function;
  - the `SYSBUS_PC`/`SYSBUS_DR`/`SYSBUS_MEM` constants shared with the control decoder.
- One sub-module: `onehot_dec`, a parameterised binary-to-one-hot decoder. Its output is registered in the parent alongside `STATE_IDX`.

## Test plan
- Reset mid-run at index 5: assert `rst` asynchronously -> `CPU_state`=9'h001 before the next edge, `FAULT`=0.
- Full ADD cycle, `RUN`=1: drive INC, INC, LD(opcode 00), INC, CLR -> indices 0,1,2,3,4,0, with `INSTR_DONE` pulsing on the final edge only.
- Load map: LD with opcodes 00/01/10/11 -> `STATE_IDX` 3/5/7/8 and `CPU_state` 9'h008/9'h020/9'h080/9'h100.
- Priority: CLR+LD+INC together at index 2 -> index 0. LD+INC together with opcode 10 -> index 7.
- Illegal INC at index 8 -> index 0 and `FAULT`=1. `FAULT` stays 1 through subsequent clears until `rst`.
- Single-step: `RUN`=0, INC held, `STEP` held for 5 cycles -> exactly one advance (0->1) and one `STEP_ACK`. Drop `STEP`, reassert -> 1->2 and a second `STEP_ACK`.
